// File: rtl/fifo_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// fifo_port_arbiter_pkg
// Shared types and defaults for the FIFO port arbiter and its round-robin
// picker: sequencer state encoding, operation kind, producer side, and the
// default data width / depth / count width.
// ----------------------------------------------------------------------------
package fifo_port_arbiter_pkg;

    localparam int DW_DEFAULT    = 8;
    localparam int DEPTH_DEFAULT = 8;
    localparam int CW_DEFAULT    = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_e;

    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } op_e;

    typedef enum logic {
        SIDE_A = 1'b0,
        SIDE_B = 1'b1
    } side_e;

    function automatic side_e other_side(input side_e s);
        return (s == SIDE_A) ? SIDE_B : SIDE_A;
    endfunction

endpackage

// File: rtl/fifo_port_arbiter_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin picker. When both sides request, the side held in the
// internal pointer wins; a lone requester always wins. Every accepted grant
// (advance=1) toggles the pointer.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset (pointer favours side A)
//   req      in   [1:0] request, bit 0 = side A, bit 1 = side B
//   advance  in   the current grant was taken this cycle
//   grant    out  [1:0] one-hot (or zero) grant, combinational
// ----------------------------------------------------------------------------
module rr_arb2
    import fifo_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    side_e ptr;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = (ptr == SIDE_A) ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state is only ever updated with non-blocking
        // assignments so every flop samples pre-edge values.
        if (!rst) begin
            ptr <= SIDE_A;
        end else if (advance) begin
            ptr <= other_side(ptr);
        end
    end

endmodule

// File: rtl/fifo_port_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_port_arbiter
// Sequences a single-port FIFO on behalf of two producers (A, B) and one
// consumer. One strobe is issued at a time, followed by GAP forced idle
// cycles so an edge-detecting FIFO sees each strobe once. A shadow occupancy
// count blocks enqueues when full and dequeues when empty. When a write and a
// read are both possible, the opposite of the last completed operation wins.
//
// Ports:
//   clk, rst             clock; asynchronous active-low reset
//   a_req/a_data/a_ack   producer A handshake (req held until ack pulse)
//   b_req/b_data/b_ack   producer B handshake
//   rd_req/rd_ack        consumer handshake
//   fifo_din             registered write data to the FIFO
//   fifo_en_in           one-cycle enqueue strobe
//   fifo_en_out          one-cycle dequeue strobe
//   occupancy            shadow entry count, 0..DEPTH
//   full, empty          occupancy==DEPTH / occupancy==0
// ----------------------------------------------------------------------------
module fifo_port_arbiter
    import fifo_port_arbiter_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int CW    = CW_DEFAULT,
    parameter int GAP   = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic [DW-1:0] a_data,
    output logic          a_ack,
    input  logic          b_req,
    input  logic [DW-1:0] b_data,
    output logic          b_ack,
    input  logic          rd_req,
    output logic          rd_ack,
    output logic [DW-1:0] fifo_din,
    output logic          fifo_en_in,
    output logic          fifo_en_out,
    output logic [CW-1:0] occupancy,
    output logic          full,
    output logic          empty
);

    state_e     state;
    op_e        cur_op;
    op_e        last_op;
    logic [2:0] gap_cnt;

    logic [1:0] grant;
    logic       wr_ok;
    logic       rd_ok;
    logic       pick_write;
    logic       pick_read;

    assign full  = (occupancy == CW'(DEPTH));
    assign empty = (occupancy == '0);

    assign wr_ok = (a_req | b_req) && !full;
    assign rd_ok = rd_req && !empty;

    // Alternate when both are possible, otherwise take whichever is possible.
    assign pick_write = wr_ok && (!rd_ok || (last_op == OP_READ));
    assign pick_read  = rd_ok && !pick_write;

    rr_arb2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     ({b_req, a_req}),
        .advance ((state == S_IDLE) && pick_write),
        .grant   (grant)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cur_op      <= OP_READ;
            last_op     <= OP_READ;
            gap_cnt     <= '0;
            occupancy   <= '0;
            fifo_din    <= '0;
            fifo_en_in  <= 1'b0;
            fifo_en_out <= 1'b0;
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            rd_ack      <= 1'b0;
        end else begin
            // Strobes and acks are single-cycle pulses.
            fifo_en_in  <= 1'b0;
            fifo_en_out <= 1'b0;
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            rd_ack      <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (pick_write) begin
                        // Data is captured here, so a producer that drops
                        // req after this edge still gets its write done.
                        cur_op     <= OP_WRITE;
                        fifo_en_in <= 1'b1;
                        fifo_din   <= grant[1] ? b_data : a_data;
                        a_ack      <= grant[0];
                        b_ack      <= grant[1];
                        state      <= S_ISSUE;
                    end else if (pick_read) begin
                        cur_op      <= OP_READ;
                        fifo_en_out <= 1'b1;
                        rd_ack      <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    // Count is committed only once the strobe has completed,
                    // so a reset during ISSUE leaves no trace.
                    if (cur_op == OP_WRITE) begin
                        occupancy <= occupancy + CW'(1);
                    end else begin
                        occupancy <= occupancy - CW'(1);
                    end
                    last_op <= cur_op;
                    gap_cnt <= 3'(GAP - 1);
                    state   <= S_GAP;
                end

                S_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 3'd1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    a_strobe_excl: assert property (@(posedge clk) disable iff (!rst)
        !(fifo_en_in && fifo_en_out));
    a_ack_excl: assert property (@(posedge clk) disable iff (!rst)
        !(a_ack && b_ack));
    a_occ_range: assert property (@(posedge clk) disable iff (!rst)
        occupancy <= CW'(DEPTH));

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fifo_port_arbiter
// Self-checking bench. A transaction-level model (next-allowed-issue cycle,
// entry count, last operation, round-robin favourite) predicts every output
// of the GAP=1 instance each cycle. A second instance with GAP=3 is used to
// measure strobe spacing directly.
// ----------------------------------------------------------------------------
module tb_fifo_port_arbiter;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = 5;
    localparam int GAP1  = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          a_req = 1'b0, b_req = 1'b0, rd_req = 1'b0;
    logic [DW-1:0] a_data = '0, b_data = '0;
    logic          a_ack, b_ack, rd_ack, fifo_en_in, fifo_en_out, full, empty;
    logic [DW-1:0] fifo_din;
    logic [CW-1:0] occupancy;

    logic          a3_req = 1'b0, b3_req = 1'b0, rd3_req = 1'b0;
    logic [DW-1:0] a3_data = '0, b3_data = '0;
    logic          f3_a_ack, f3_b_ack, f3_rd_ack, f3_en_in, f3_en_out, f3_full, f3_empty;
    logic [DW-1:0] f3_din;
    logic [CW-1:0] f3_occ;

    always #5 clk = ~clk;

    fifo_port_arbiter #(.DW(DW), .DEPTH(DEPTH), .CW(CW), .GAP(GAP1)) u_dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_data(a_data), .a_ack(a_ack),
        .b_req(b_req), .b_data(b_data), .b_ack(b_ack),
        .rd_req(rd_req), .rd_ack(rd_ack),
        .fifo_din(fifo_din), .fifo_en_in(fifo_en_in), .fifo_en_out(fifo_en_out),
        .occupancy(occupancy), .full(full), .empty(empty)
    );

    fifo_port_arbiter #(.DW(DW), .DEPTH(DEPTH), .CW(CW), .GAP(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .a_req(a3_req), .a_data(a3_data), .a_ack(f3_a_ack),
        .b_req(b3_req), .b_data(b3_data), .b_ack(f3_b_ack),
        .rd_req(rd3_req), .rd_ack(f3_rd_ack),
        .fifo_din(f3_din), .fifo_en_in(f3_en_in), .fifo_en_out(f3_en_out),
        .occupancy(f3_occ), .full(f3_full), .empty(f3_empty)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state
    int            m_occ;
    bit            m_last_write;  // last completed op was a write
    bit            m_fav_b;       // round-robin favourite is B
    int            m_ready;       // first cycle a new op may be chosen
    int            m_pending;     // 0 none, 1 write in flight, 2 read in flight
    bit            e_en_in, e_en_out, e_a_ack, e_b_ack, e_rd_ack;
    logic [DW-1:0] e_din;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_occ = 0; m_last_write = 1'b0; m_fav_b = 1'b0; m_ready = 0; m_pending = 0;
        e_en_in = 0; e_en_out = 0; e_a_ack = 0; e_b_ack = 0; e_rd_ack = 0; e_din = '0;
    endtask

    task automatic check_all();
        check("fifo_en_in",  fifo_en_in,  e_en_in);
        check("fifo_en_out", fifo_en_out, e_en_out);
        check("a_ack",       a_ack,       e_a_ack);
        check("b_ack",       b_ack,       e_b_ack);
        check("rd_ack",      rd_ack,      e_rd_ack);
        check("fifo_din",    fifo_din,    e_din);
        check("occupancy",   occupancy,   m_occ);
        check("full",        full,        m_occ == DEPTH);
        check("empty",       empty,       m_occ == 0);
    endtask

    // One clock: update the model from the inputs seen at the edge, then
    // compare every output 1 time unit later.
    task automatic step();
        bit sa, sb, sr, wr_ok, rd_ok, pick_w, use_b;
        logic [DW-1:0] da, db;
        @(posedge clk);
        cyc++;
        sa = a_req; sb = b_req; sr = rd_req; da = a_data; db = b_data;
        e_en_in = 0; e_en_out = 0; e_a_ack = 0; e_b_ack = 0; e_rd_ack = 0;
        if (rst) begin
            if (cyc >= m_ready) begin
                wr_ok  = (sa || sb) && (m_occ < DEPTH);
                rd_ok  = sr && (m_occ > 0);
                pick_w = wr_ok && (!rd_ok || !m_last_write);
                if (pick_w) begin
                    use_b     = (sa && sb) ? m_fav_b : sb;
                    m_fav_b   = !m_fav_b;
                    e_din     = use_b ? db : da;
                    e_en_in   = 1; e_a_ack = !use_b; e_b_ack = use_b;
                    m_pending = 1;
                    m_ready   = cyc + GAP1 + 2;
                end else if (rd_ok) begin
                    e_en_out  = 1; e_rd_ack = 1;
                    m_pending = 2;
                    m_ready   = cyc + GAP1 + 2;
                end
            end else if (m_pending == 1) begin
                m_occ++; m_last_write = 1'b1; m_pending = 0;
            end else if (m_pending == 2) begin
                m_occ--; m_last_write = 1'b0; m_pending = 0;
            end
        end
        #1;
        check_all();
    endtask

    // mode 0: hold requests; mode 1: drop each request on its ack;
    // mode 2: random requesters that drop on ack and occasionally give up.
    task automatic run(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            step();
            if (mode == 1) begin
                if (e_a_ack)  a_req  = 1'b0;
                if (e_b_ack)  b_req  = 1'b0;
                if (e_rd_ack) rd_req = 1'b0;
            end else if (mode == 2) begin
                if (e_a_ack || (a_req && $urandom_range(15) == 0)) a_req = 1'b0;
                else if (!a_req && $urandom_range(2) == 0) begin a_req = 1'b1; a_data = DW'($urandom); end
                if (e_b_ack || (b_req && $urandom_range(15) == 0)) b_req = 1'b0;
                else if (!b_req && $urandom_range(2) == 0) begin b_req = 1'b1; b_data = DW'($urandom); end
                if (e_rd_ack) rd_req = 1'b0;
                else if (!rd_req && $urandom_range(2) == 0) rd_req = 1'b1;
            end
        end
    endtask

    initial begin
        int start3, last3, n3, acks3;

        // Reset state
        model_reset();
        run(3, 0);
        rst = 1'b1;
        run(2, 0);

        // Single write from A, data 8'h53
        a_req = 1'b1; a_data = 8'h53;
        run(1, 1);
        check("t1_en_in", fifo_en_in, 1'b1);
        check("t1_din",   fifo_din,   8'h53);
        check("t1_ack",   a_ack,      1'b1);
        run(4, 1);
        check("t1_occ",   occupancy,  1);
        check("t1_empty", empty,      1'b0);

        // Both producers held: alternate A,B until full, then stall
        a_req = 1'b1; a_data = 8'hA1; b_req = 1'b1; b_data = 8'hB2;
        run(30, 0);
        check("t2_full", full,      1'b1);
        check("t2_occ",  occupancy, DEPTH);

        // Full with all three held: read first, then alternate
        rd_req = 1'b1;
        run(20, 0);
        a_req = 1'b0; b_req = 1'b0;
        run(35, 0);
        check("t3_drained", empty, 1'b1);

        // Read held while empty: nothing issues
        run(6, 0);
        check("t4_no_read", fifo_en_out, 1'b0);

        // Write 8'h5A, then the held read follows GAP+2 cycles later
        a_req = 1'b1; a_data = 8'h5A;
        run(8, 1);
        check("t4_occ", occupancy, 0);

        // Reset asserted during ISSUE of a write
        a_req = 1'b1; a_data = 8'h77;
        run(1, 1);
        check("t5_in_issue", fifo_en_in, 1'b1);
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        run(2, 0);
        rst = 1'b1;
        run(4, 0);
        check("t5_occ", occupancy, 0);

        // Randomised traffic
        run(600, 2);
        a_req = 1'b0; b_req = 1'b0; rd_req = 1'b0;
        run(5, 0);

        // GAP=3 instance: back-to-back writes from A, 5-cycle spacing
        a3_req = 1'b1; a3_data = 8'h3C;
        start3 = cyc; last3 = 0; n3 = 0; acks3 = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (f3_a_ack) acks3++;
            if (f3_en_in) begin
                if (n3 == 0) check("gap3_first", cyc - start3, 1);
                else         check("gap3_spacing", cyc - last3, 5);
                last3 = cyc;
                n3++;
            end
        end
        check("gap3_pulses", n3,       DEPTH);
        check("gap3_acks",   acks3,    DEPTH);
        check("gap3_full",   f3_full,  1'b1);
        check("gap3_occ",    f3_occ,   DEPTH);
        check("gap3_empty",  f3_empty, 1'b0);
        check("gap3_din",    f3_din,   8'h3C);
        check("gap3_en_out", f3_en_out, 1'b0);
        check("gap3_b_ack",  f3_b_ack | f3_rd_ack, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
